// File: rtl/dct_pkg.sv
// Shared constants and helpers for the 2-D DCT pipeline.
// The transpose swizzle turns a column-major output index into a row-major storage address.
package dct_pkg;

  localparam int DCT_N = 8;
  localparam int BLK   = DCT_N * DCT_N;
  localparam int W_ROW = 12;
  localparam int W_COL = 15;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  function automatic logic [5:0] transpose_addr(input logic [5:0] idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One 64-entry coefficient bank: flop array, single write port, asynchronous read port.
// Contents are deliberately left unreset; the full flags decide what is meaningful.
module transpose_bank
  import dct_pkg::*;
#(
  parameter int W = W_ROW
) (
  input  logic         clk,
  input  logic         we,
  input  logic [5:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [5:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [BLK];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dct_transpose_buffer.sv
// Double-buffered 8x8 transpose between the row and column DCT passes.
// One bank fills in row-major order while the other drains column-major.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int W = W_ROW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_first,
  output logic         out_last,
  output logic         overflow
);

  localparam logic [5:0] LAST = 6'(BLK - 1);

  logic         wbank;
  logic [5:0]   waddr;
  logic         rbank;
  logic [5:0]   ridx;
  logic [1:0]   full;
  logic         wr_en;
  logic         load;
  logic         rd_done;
  logic [5:0]   raddr;
  logic [W-1:0] rdata [2];
  rd_state_t    state;
  rd_state_t    state_nxt;

  assign wr_en = in_valid && !full[wbank];
  assign raddr = transpose_addr(ridx);

  transpose_bank #(.W(W)) u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wbank),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata[0])
  );

  transpose_bank #(.W(W)) u_bank1 (
    .clk   (clk),
    .we    (wr_en && wbank),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata[1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank    <= 1'b0;
      waddr    <= 6'd0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      if (!full[wbank]) begin
        waddr <= waddr + 6'd1;
        if (waddr == LAST) begin
          wbank <= ~wbank;
        end
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // Set and clear always target different banks, so both may land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_en && (waddr == LAST)) begin
        full[wbank] <= 1'b1;
      end
      if (rd_done) begin
        full[rbank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rd_done   = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rbank]) begin
          state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        load = !out_valid || out_ready;
        if (load && (ridx == LAST)) begin
          rd_done   = 1'b1;
          state_nxt = full[~rbank] ? RD_DRAIN : RD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbank     <= 1'b0;
      ridx      <= 6'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= rdata[rbank];
      out_first <= (ridx == 6'd0);
      out_last  <= (ridx == LAST);
      ridx      <= ridx + 6'd1;
      if (ridx == LAST) begin
        rbank <= ~rbank;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: table of scenarios plus hand-written corner sequences.
// Expected output comes from a block-level transpose model feeding a scoreboard queue.
module tb_dct_transpose_buffer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;
  logic         overflow;

  always #5 clk = ~clk;

  dct_transpose_buffer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  typedef struct {
    string name;
    int    gap;
    int    rmode;
    int    nsamp;
    int    base;
    int    base2;
    bit    rnd;
    bit    chk_lat;
    bit    chk_contig;
    int    exp_outs;
    int    exp_ovf;
  } vec_t;

  vec_t         vecs [5];
  int           checks = 0;
  int           fails = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] cur_blk [64];
  int           mcnt = 0;
  int           out_pos = 0;
  int           n_xfer = 0;
  int           ready_mode = 0;
  int           rphase = 0;
  int           run_len = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] held;
  logic [W-1:0] e;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a completed block is emitted column by column.
  task automatic modelSample(input logic [W-1:0] v);
    cur_blk[mcnt] = v;
    mcnt++;
    if (mcnt == 64) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++)
          exp_q.push_back(cur_blk[r*8 + c]);
      mcnt = 0;
    end
  endtask

  task automatic applyStimulus(input int n, input int gap, input int base, input int base2,
                               input bit rnd, input bit acc);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] v;
      if (rnd) v = W'($urandom);
      else     v = W'((i < 64) ? (base + i) : (base2 + i - 64));
      in_valid = 1'b1;
      in_data  = v;
      if (acc) modelSample(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      if (i < n - 1) begin
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data",  int'(out_data),  0);
    checkOutput("rst_out_first", int'(out_first), 0);
    checkOutput("rst_out_last",  int'(out_last),  0);
    checkOutput("rst_overflow",  int'(overflow),  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mcnt    = 0;
    out_pos = 0;
    n_xfer  = 0;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("drain_remaining", exp_q.size(), 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_after_drain", int'(out_valid), 0);
  endtask

  task automatic measureRun(output int run);
    int t;
    t   = 0;
    run = 0;
    while (!out_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    while (out_valid && run < 300) begin
      run++;
      @(negedge clk);
    end
  endtask

  // Column-stage handshake driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rphase == 0);
          rphase    = (rphase + 1) % 3;
        end
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", int'({out_valid, out_data}), int'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data",  int'(out_data),  int'(e));
          checkOutput("out_first", int'(out_first), int'(out_pos == 0));
          checkOutput("out_last",  int'(out_last),  int'(out_pos == 63));
          out_pos = (out_pos + 1) % 64;
          n_xfer++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = out_data;
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    vecs[0] = '{"ramp",         0, 0,  64,   0,    0, 1'b0, 1'b1, 1'b0,  64, 0};
    vecs[1] = '{"back_to_back", 0, 0, 128,   0,  100, 1'b0, 1'b0, 1'b1, 128, 0};
    vecs[2] = '{"gappy",        2, 0,  64,   0,    0, 1'b0, 1'b1, 1'b0,  64, 0};
    vecs[3] = '{"backpressure", 0, 1, 128, 500, -200, 1'b0, 1'b0, 1'b0, 128, 0};
    vecs[4] = '{"random",      -1, 2, 256,   0,    0, 1'b1, 1'b0, 1'b0, 256, 0};

    for (int k = 0; k < 5; k++) begin
      $display("[TB] scenario %s", vecs[k].name);
      ready_mode = vecs[k].rmode;
      doReset();
      fork
        applyStimulus(vecs[k].nsamp, vecs[k].gap, vecs[k].base, vecs[k].base2, vecs[k].rnd, 1'b1);
        if (vecs[k].chk_contig) measureRun(run_len);
      join
      if (vecs[k].chk_contig) checkOutput("contiguous_run", run_len, vecs[k].exp_outs);
      if (vecs[k].chk_lat) begin
        checkOutput("lat_edge_n", int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge_n1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge_n2_valid", int'(out_valid), 1);
        checkOutput("lat_edge_n2_first", int'(out_first), 1);
        checkOutput("lat_edge_n2_data",  int'(out_data), vecs[k].base);
      end
      waitDrain();
      checkOutput("xfer_count", n_xfer, vecs[k].exp_outs);
      checkOutput("overflow_flag", int'(overflow), vecs[k].exp_ovf);
    end

    $display("[TB] scenario overflow");
    ready_mode = 3;
    doReset();
    applyStimulus(128, 0, 0, 1000, 1'b0, 1'b1);
    checkOutput("ovf_before_drop", int'(overflow), 0);
    applyStimulus(1, 0, 2000, 0, 1'b0, 1'b0);
    checkOutput("ovf_after_drop", int'(overflow), 1);
    ready_mode = 0;
    waitDrain();
    checkOutput("ovf_xfer_count", n_xfer, 128);
    checkOutput("ovf_sticky", int'(overflow), 1);

    $display("[TB] scenario reset mid-block");
    ready_mode = 0;
    doReset();
    applyStimulus(30, 0, 3000, 0, 1'b0, 1'b0);
    doReset();
    applyStimulus(64, 0, 0, 0, 1'b0, 1'b1);
    waitDrain();
    checkOutput("midrst_xfer_count", n_xfer, 64);
    checkOutput("midrst_overflow", int'(overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
